// File: rtl/serial_mult_pkg.sv
// -----------------------------------------------------------------------------
// serial_mult_pkg
// Shared definitions for the shift-add serial multiplier sequencer:
//   - state_t        : sequencer FSM state encoding (2 bits)
//   - DEFAULT_WIDTH  : default operand width
//   - cnt_w()        : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package serial_mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit over clog2 so the counter can reach WIDTH-1 for any
    // legal WIDTH without wrapping inside a transaction.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// -----------------------------------------------------------------------------
// shift_add_datapath
// Holds the shift-add multiplier registers: accumulator P, multiplier /
// low-product Q and multiplicand M, plus the WIDTH-bit adder.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, clears P, Q, M
//   load     in   P <= 0, Q <= load_a, M <= load_b
//   step     in   one shift-add step: {P,Q} <= {P + (add ? M : 0), Q} >> 1
//   add      in   include M in this step's sum (driven from Q[0] by the
//                 sequencer)
//   load_a   in   WIDTH    multiplier operand, loaded into Q
//   load_b   in   WIDTH    multiplicand operand, loaded into M
//   product  out  2*WIDTH  live {P,Q}
//   q0       out  1        Q[0], the current multiplier bit
// -----------------------------------------------------------------------------
module shift_add_datapath
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 add,
    input  logic [WIDTH-1:0]     load_a,
    input  logic [WIDTH-1:0]     load_b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 q0
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;

    // NOTE: sum is WIDTH+1 bits so the adder carry survives and becomes P's
    // MSB after the shift; a WIDTH-bit sum would silently drop it.
    always_comb begin
        addend = '0;
        if (add) begin
            addend = {1'b0, m};
        end
        sum = {1'b0, p} + addend;
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // register sees the pre-edge values of the others (the shift relies on it).
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
            q <= '0;
            m <= '0;
        end else if (load) begin
            p <= '0;
            q <= load_a;
            m <= load_b;
        end else if (step) begin
            {p, q} <= {sum, q[WIDTH-1:1]};
        end
    end

    assign product = {p, q};
    assign q0      = q[0];

endmodule

// File: rtl/serial_mult_sequencer.sv
// -----------------------------------------------------------------------------
// serial_mult_sequencer
// Runs one unsigned shift-add multiplication per transaction: accepts an
// operand pair on a valid/ready handshake, performs WIDTH shift-add steps on
// the shift_add_datapath, and presents the 2*WIDTH-bit product on a
// valid/ready handshake.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   in_valid     in   operand pair valid
//   in_ready     out  operands accepted (high only in IDLE)
//   in_a         in   WIDTH    multiplier operand (loaded into Q)
//   in_b         in   WIDTH    multiplicand operand (loaded into M)
//   out_valid    out  product valid (high only in DONE)
//   out_ready    in   consumer accepts the product
//   out_product  out  2*WIDTH  {P,Q}, stable while out_valid is high
//   busy         out  high while stepping (RUN)
//
// Build option:
//   SERIAL_MULT_ZERO_BYPASS_EN - when defined, a pair with a zero operand is
//   loaded as 0 and goes straight from IDLE to DONE, never asserting busy.
// -----------------------------------------------------------------------------
module serial_mult_sequencer
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               load;
    logic               step;
    logic               add;
    logic               q0;
    logic [WIDTH-1:0]   load_a;
    logic [WIDTH-1:0]   load_b;

`ifdef SERIAL_MULT_ZERO_BYPASS_EN
    logic zero_pair;
    assign zero_pair = (in_a == '0) || (in_b == '0);
    // Forcing Q to 0 makes {P,Q} == 0 regardless of which operand was zero.
    assign load_a    = zero_pair ? '0 : in_a;
`else
    assign load_a    = in_a;
`endif
    assign load_b = in_b;

    assign load = (state == IDLE) && in_valid;
    assign step = (state == RUN);
    assign add  = step && q0;

    shift_add_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .add     (add),
        .load_a  (load_a),
        .load_b  (load_b),
        .product (out_product),
        .q0      (q0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        count    <= '0;
                        in_ready <= 1'b0;
`ifdef SERIAL_MULT_ZERO_BYPASS_EN
                        if (zero_pair) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`else
                        state <= RUN;
                        busy  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    // The datapath performs its last step on this same edge.
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
